// File: rtl/freq_meter_controller.sv
// freq_meter_controller: gated edge counter for the frequency meter.
// Synchronises sig_in, counts rising edges in a gate window, latches result.
module freq_meter_controller #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 32,
    parameter int TIMER_W     = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic [1:0]       gate_sel,
    output logic             busy,
    output logic [CNT_W-1:0] freq_count,
    output logic             result_valid,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        LATCH   = 2'd3
    } state_t;

    // Last timer value of each window (window length minus one)
    localparam logic [TIMER_W-1:0] LAST0 = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LAST1 = TIMER_W'(GATE_CYCLES / 10 - 1);
    localparam logic [TIMER_W-1:0] LAST2 = TIMER_W'(GATE_CYCLES / 100 - 1);
    localparam logic [TIMER_W-1:0] LAST3 = TIMER_W'(GATE_CYCLES / 1000 - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    state_t             state_q;
    logic               s1_q, s2_q, s3_q;
    logic               edge_w;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] last_q, last_d;
    logic               busy_q;
    logic [CNT_W-1:0]   freq_q;
    logic               valid_q;
    logic               ovf_q;

    assign edge_w = s2_q & ~s3_q;

    // Window length selected by gate_sel, loaded whenever ARM is entered
    always_comb begin
        last_d = LAST0;
        case (gate_sel)
            2'd0:    last_d = LAST0;
            2'd1:    last_d = LAST1;
            2'd2:    last_d = LAST2;
            2'd3:    last_d = LAST3;
            default: last_d = LAST0;
        endcase
    end

    // Saturating edge count including this cycle's edge
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (edge_w) begin
            if (cnt_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser chain plus sequencing FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            timer_q <= '0;
            last_q  <= '0;
            busy_q  <= 1'b0;
            freq_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= sig_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            valid_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= ARM;
                            busy_q  <= 1'b1;
                            last_q  <= last_d;
                        end
                    end
                    ARM: begin
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                        timer_q <= '0;
                        state_q <= MEASURE;
                    end
                    MEASURE: begin
                        timer_q <= timer_q + TIMER_W'(1);
                        cnt_q   <= cnt_d;
                        sat_q   <= sat_d;
                        // Latch on the way out so the final cycle's edge
                        // is included and the result lines up with LATCH
                        if (timer_q == last_q) begin
                            state_q <= LATCH;
                            freq_q  <= cnt_d;
                            ovf_q   <= sat_d;
                            valid_q <= 1'b1;
                        end
                    end
                    LATCH: begin
                        if (continuous) begin
                            state_q <= ARM;
                            last_q  <= last_d;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy         = busy_q;
    assign freq_count   = freq_q;
    assign result_valid = valid_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_freq_meter_controller.sv
// tb_freq_meter_controller: scoreboard bench for the frequency meter.
// Stimulus pushes expected results; negedge monitors pop and compare.
module tb_freq_meter_controller;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sig_in;
    logic        start, start2;
    logic        continuous;
    logic        abort;
    logic [1:0]  gate_sel;
    logic        busy, busy2;
    logic [31:0] freq_count;
    logic [3:0]  freq_count2;
    logic        result_valid, result_valid2;
    logic        overflow, overflow2;

    logic gen_en, gen_sig, man_sig;
    int   period;
    int   ph;
    int   cyc;
    int   compared;
    int   mismatched;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    always #5 clk = ~clk;

    assign sig_in = gen_en ? gen_sig : man_sig;

    freq_meter_controller #(
        .GATE_CYCLES(1000), .CNT_W(32), .TIMER_W(10)
    ) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
        .continuous(continuous), .abort(abort), .gate_sel(gate_sel),
        .busy(busy), .freq_count(freq_count),
        .result_valid(result_valid), .overflow(overflow)
    );

    freq_meter_controller #(
        .GATE_CYCLES(1000), .CNT_W(4), .TIMER_W(10)
    ) dut_ov (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start2),
        .continuous(1'b0), .abort(1'b0), .gate_sel(gate_sel),
        .busy(busy2), .freq_count(freq_count2),
        .result_valid(result_valid2), .overflow(overflow2)
    );

    // Cycle counter used for latency checks
    always @(posedge clk) cyc++;

    // Clock-synchronous periodic test signal
    always @(negedge clk) begin
        if (ph >= period - 1) ph = 0;
        else ph++;
        gen_sig = (ph < period / 2);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for the 32-bit instance
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (q1.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: got count %0d, want no result", freq_count);
            end else begin
                e1 = q1.pop_front();
                chk("count", freq_count, e1.cnt);
                chk("overflow", {31'd0, overflow}, {31'd0, e1.ovf});
                chk("latency", cyc, e1.cyc);
            end
        end
    end

    // Monitor for the 4-bit instance
    always @(negedge clk) begin
        if (result_valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result4: got count %0d, want no result", freq_count2);
            end else begin
                e2 = q2.pop_front();
                chk("count4", {28'd0, freq_count2}, e2.cnt);
                chk("overflow4", {31'd0, overflow2}, {31'd0, e2.ovf});
                chk("latency4", cyc, e2.cyc);
            end
        end
    end

    task automatic pulse_start(output int ct);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ct = cyc;
    endtask

    task automatic pulse_start2(output int ct);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        ct = cyc;
    endtask

    task automatic push1(int cnt, bit ovf, int c);
        exp_t e;
        e.cnt = cnt;
        e.ovf = ovf;
        e.cyc = c;
        q1.push_back(e);
    endtask

    task automatic push2(int cnt, bit ovf, int c);
        exp_t e;
        e.cnt = cnt;
        e.ovf = ovf;
        e.cyc = c;
        q2.push_back(e);
    endtask

    task automatic drain(int budget);
        for (int i = 0; i < budget; i++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: got %0d/%0d pending results, want 0", q1.size(), q2.size());
            q1.delete();
            q2.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int ct;
        compared = 0;
        mismatched = 0;
        cyc = 0;
        ph = 0;
        period = 10;
        gen_en = 1'b0;
        man_sig = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        continuous = 1'b0;
        abort = 1'b0;
        gate_sel = 2'd0;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_count", freq_count, 0);
        chk("rst_valid", {31'd0, result_valid}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        reset = 1'b0;

        // Basic count: 1000-cycle window, period 10
        gen_en = 1'b1;
        period = 10;
        repeat (20) @(negedge clk);
        pulse_start(ct);
        push1(100, 0, ct + 1001);
        chk("busy_arm", {31'd0, busy}, 1);
        drain(1100);
        chk("busy_after", {31'd0, busy}, 0);

        // Gate select /100
        gate_sel = 2'd2;
        pulse_start(ct);
        push1(1, 0, ct + 11);
        drain(50);

        // Gate select /10, gate_sel change and stray start mid-window
        gate_sel = 2'd1;
        pulse_start(ct);
        push1(10, 0, ct + 101);
        repeat (30) @(negedge clk);
        gate_sel = 2'd3;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(150);
        repeat (120) @(negedge clk);
        chk("busy_one_result", {31'd0, busy}, 0);

        // Abort at cycle 50 keeps the previous result (10)
        gate_sel = 2'd1;
        pulse_start(ct);
        repeat (50) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {31'd0, busy}, 0);
        repeat (120) @(negedge clk);
        chk("abort_keep", freq_count, 10);

        // abort together with start in IDLE stays idle
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start", {31'd0, busy}, 0);
        repeat (5) @(negedge clk);

        // Continuous: period 5, 100-cycle windows
        period = 5;
        repeat (20) @(negedge clk);
        continuous = 1'b1;
        pulse_start(ct);
        push1(20, 0, ct + 101);
        push1(20, 0, ct + 203);
        push1(20, 0, ct + 305);
        repeat (250) @(negedge clk);
        continuous = 1'b0;
        drain(200);
        repeat (5) @(negedge clk);
        chk("cont_stop", {31'd0, busy}, 0);

        // Overflow on the 4-bit instance: 25 edges saturate at 15
        period = 4;
        repeat (20) @(negedge clk);
        gate_sel = 2'd1;
        pulse_start2(ct);
        push2(15, 1, ct + 101);
        drain(150);
        gen_en = 1'b0;
        man_sig = 1'b0;
        repeat (10) @(negedge clk);
        pulse_start2(ct);
        push2(0, 0, ct + 101);
        drain(150);

        // Edge in the final MEASURE cycle is counted
        gate_sel = 2'd2;
        pulse_start(ct);
        push1(1, 0, ct + 11);
        repeat (8) @(negedge clk);
        man_sig = 1'b1;
        repeat (3) @(negedge clk);
        man_sig = 1'b0;
        drain(50);

        // Edge one cycle later falls into the blind LATCH cycle
        pulse_start(ct);
        push1(0, 0, ct + 11);
        repeat (9) @(negedge clk);
        man_sig = 1'b1;
        repeat (3) @(negedge clk);
        man_sig = 1'b0;
        drain(50);

        // Restore a nonzero result, then reset mid-window
        gen_en = 1'b1;
        period = 10;
        repeat (20) @(negedge clk);
        pulse_start(ct);
        push1(1, 0, ct + 11);
        drain(50);
        gate_sel = 2'd1;
        pulse_start(ct);
        repeat (30) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_busy", {31'd0, busy}, 0);
        chk("areset_count", freq_count, 0);
        chk("areset_valid", {31'd0, result_valid}, 0);
        chk("areset_overflow", {31'd0, overflow}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (120) @(negedge clk);
        chk("areset_idle", {31'd0, busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/freq_meter_controller.md
# freq_meter_controller

Sequencing controller for the frequency meter. It synchronises the external signal, detects its rising edges, and runs a programmable gate window timer. It counts edges inside the window, then latches the count as the measurement result with a one-cycle valid strobe. It supports single-shot, continuous and abort operation, and sits between the raw input pin and the display/readout logic.

## Interface
- GATE_CYCLES, 100_000_000: base gate length in clk cycles (1 s at 100 MHz). Must be a multiple of 1000 and at least 1000.
- CNT_W, 32: width of the edge counter and of the result.
- TIMER_W, 27: gate timer width. Must satisfy 2^TIMER_W > GATE_CYCLES.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sig_in  in  1  measured signal, asynchronous to clk.
- start  in  1  level/pulse request to begin a measurement; sampled only in IDLE.
- continuous  in  1  when high, a new window starts automatically after each result; sampled in LATCH.
- abort  in  1  cancels the current measurement; takes priority over all other inputs.
- gate_sel  in  2  gate length: 0 = GATE_CYCLES, 1 = /10, 2 = /100, 3 = /1000. Captured on entry to ARM.
- busy  out  1  high in ARM, MEASURE and LATCH.
- freq_count  out  CNT_W  last latched edge count; holds until the next LATCH.
- result_valid  out  1  one-cycle pulse coinciding with the freq_count update.
- overflow  out  1  saturation flag of the latched result; updated with freq_count.

## Operation
- Input path: 3-flop chain s1 <= sig_in, s2 <= s1, s3 <= s2.
  - edge = s2 & ~s3.
  - s1 and s2 form the synchroniser; edge is a one-cycle pulse per rising edge of sig_in.
  - The chain runs in all states, so edges are tracked continuously.
- States: IDLE, ARM, MEASURE, LATCH (2-bit encoding).
- IDLE:
  - busy = 0.
  - start = 1 moves to ARM.
- ARM (exactly 1 cycle):
  - edge counter cleared to 0, sat flag cleared, timer cleared to 0.
  - gate_len register loaded from gate_sel.
  - Next state is MEASURE.
- MEASURE:
  - The timer increments every cycle.
  - Each cycle with edge = 1 increments the counter.
  - At counter = 2^CNT_W − 1, a further edge leaves the counter unchanged and sets sat.
  - When timer == gate_len − 1, the next state is LATCH.
  - The window is therefore exactly gate_len cycles. An edge in the final MEASURE cycle is counted.
- LATCH (exactly 1 cycle):
  - freq_count <= counter, overflow <= sat, result_valid = 1.
  - Next state is ARM if continuous = 1, else IDLE.
- abort = 1 in any state forces IDLE on the next edge.
  - No result_valid; freq_count and overflow keep their previous values.
  - abort together with start in IDLE stays in IDLE.
- start while busy is ignored; it is not queued.
- gate_sel changes while busy have no effect until the next ARM.
- Gate lengths are localparams computed from GATE_CYCLES. No runtime division.

## Timing
- Reset values: state = IDLE; busy = 0, freq_count = 0, result_valid = 0, overflow = 0; s1/s2/s3 = 0; counter = 0, timer = 0.
- Reset is asynchronous. Asserting it mid-measurement discards the window immediately, with no result_valid.
- Synchroniser latency:
  - A sig_in rise sampled at clk edge k gives edge = 1 during the cycle following edge k+1.
  - A rise closer than 2 cycles before window end is counted in the next window, or lost in single-shot.
- Start to result:
  - start sampled high at edge t gives ARM in cycle t+1, MEASURE in cycles t+2 .. t+1+gate_len, LATCH in cycle t+2+gate_len.
  - result_valid is high and freq_count updated in that LATCH cycle.
- Continuous mode: a result every gate_len + 2 cycles. The ARM and LATCH cycles are blind; edges in them are not counted.
- busy rises the cycle after start is accepted. It falls the cycle after LATCH when not continuous.
- Maximum countable input frequency is clk/2: edges need sig_in high ≥ 1 cycle and low ≥ 1 cycle.

## Test plan
- Basic count: GATE_CYCLES = 1000, gate_sel = 0, sig_in period 10 clk running before start, single 1-cycle start.
  - Required: exactly one result_valid, 1002 cycles after start, with freq_count = 100, overflow = 0, busy = 0 afterwards.
- Gate select: same sig_in, gate_sel = 2 (window 10).
  - Required: freq_count = 1. Then gate_sel = 1 (window 100) gives freq_count = 10.
  - gate_sel changed mid-window does not alter that window's count.
- Continuous: continuous = 1, gate_sel = 1, sig_in period 5.
  - Required: result_valid every 102 cycles, freq_count = 20 each time (±1 allowed only for a blind-cycle edge).
  - Dropping continuous stops after the current result.
- Overflow: CNT_W = 4, window 100, sig_in period 4 (25 edges).
  - Required: freq_count = 15, overflow = 1.
  - A following window with sig_in held low gives freq_count = 0, overflow = 0.
- Abort and reset: abort at cycle 50 of the window.
  - Required: IDLE next cycle, no result_valid, freq_count keeps its prior value.
  - Separately, asserting reset mid-window clears all outputs to 0 asynchronously, before the next clk edge.
- Start while busy and boundary edge: a second start pulse during MEASURE is ignored (one result only).
  - An edge pulse landing in the final MEASURE cycle is included in freq_count.
